mem_port_arbiter: RTL and testbench

//  Shares one single-ported, fixed-latency 16-bit memory between the IF stage (instruction fetch) and the MEM stage (load/store).

---
 rtl/mem_port_arbiter_pkg.sv | 31 +++
 rtl/mem_arb_timer.sv | 27 ++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory port arbiter: word size, FSM states,
// owner encoding and the latched grant record.
package mem_port_arbiter_pkg;

    localparam int WORD_SIZE = 16;

    typedef logic [WORD_SIZE-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef struct packed {
        owner_t owner;
        logic   we;
        word_t  addr;
        word_t  wdata;
    } grant_t;

    function automatic word_t sat_inc(input word_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Loadable down-counter timing the fixed memory latency; zero flags the
// last cycle of an access.
module mem_arb_timer #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between fetch and data ports, data first
// with a fetch starvation guard. Optional statistics under `ARB_STATS_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LATENCY  = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_ack,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ack,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic [WORD_SIZE-1:0] stat_i_wait,
    output logic [WORD_SIZE-1:0] stat_d_grants
);

    localparam int unsigned TW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    state_t        state, state_nxt;
    grant_t        grant_q, grant_nxt;
    logic [SW-1:0] starve_cnt;
    logic          grant_en, pick_d, lat_zero, last_beat;
    word_t         i_rdata_q, d_rdata_q;

    // Data wins unless fetch is also waiting and has already lost STARVE_LIMIT times.
    assign grant_en  = (state == ST_IDLE) && (i_req || d_req);
    assign pick_d    = d_req && (!i_req || (starve_cnt < SW'(STARVE_LIMIT)));
    assign last_beat = (state == ST_BUSY) && lat_zero;

    always_comb begin
        grant_nxt = '0;
        if (pick_d) begin
            grant_nxt.owner = OWN_D;
            grant_nxt.we    = d_we;
            grant_nxt.addr  = d_addr;
            grant_nxt.wdata = d_wdata;
        end else begin
            grant_nxt.owner = OWN_I;
            grant_nxt.we    = 1'b0;
            grant_nxt.addr  = i_addr;
            grant_nxt.wdata = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (i_req || d_req) state_nxt = ST_BUSY;
            ST_BUSY: if (lat_zero)       state_nxt = ST_DONE;
            ST_DONE:                     state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        unique case (state)
            ST_BUSY: begin
                mem_read  = ~grant_q.we;
                mem_write = grant_q.we;
                mem_addr  = grant_q.addr;
                mem_wdata = grant_q.wdata;
            end
            ST_DONE: begin
                i_ack = (grant_q.owner == OWN_I);
                d_ack = (grant_q.owner == OWN_D);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q    <= '0;
            starve_cnt <= '0;
        end else if (grant_en) begin
            grant_q    <= grant_nxt;
            starve_cnt <= (pick_d && i_req) ? starve_cnt + 1'b1 : '0;
        end
    end

    mem_arb_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (grant_en),
        .value  (TW'(MEM_LATENCY - 1)),
        .zero   (lat_zero)
    );

    // Read data lands on the final busy cycle; stores leave both registers alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else if (last_beat && !grant_q.we) begin
            if (grant_q.owner == OWN_D) begin
                d_rdata_q <= mem_rdata;
            end else begin
                i_rdata_q <= mem_rdata;
            end
        end
    end

    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

`ifdef ARB_STATS_EN
    word_t i_wait_q, d_grants_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_wait_q   <= '0;
            d_grants_q <= '0;
        end else begin
            if (i_req && !i_ack) begin
                i_wait_q <= sat_inc(i_wait_q);
            end
            if (grant_en && pick_d) begin
                d_grants_q <= sat_inc(d_grants_q);
            end
        end
    end

    assign stat_i_wait   = i_wait_q;
    assign stat_d_grants = d_grants_q;
`else
    assign stat_i_wait   = '0;
    assign stat_d_grants = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (latency 2 / limit 4 and
// latency 1 / limit 1) checked every cycle against a transaction-timeline model.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset_n;

    logic        i_req[2], d_req[2], d_we[2];
    logic [15:0] i_addr[2], d_addr[2], d_wdata[2], mem_rdata[2];
    logic        i_ack[2], d_ack[2], mem_read[2], mem_write[2];
    logic [15:0] i_rdata[2], d_rdata[2], mem_addr[2], mem_wdata[2];
    logic [15:0] stat_i_wait[2], stat_d_grants[2];

    int vecs = 0;
    int errs = 0;
    bit poke[2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bit          wr[256];
        logic [15:0] st[256];

        always @(posedge clk) begin
            if (mem_write[g]) begin
                wr[mem_addr[g][7:0]] <= 1'b1;
                st[mem_addr[g][7:0]] <= mem_wdata[g];
            end
        end

        assign mem_rdata[g] = !mem_read[g] ? 16'h0000 :
                              wr[mem_addr[g][7:0]] ? st[mem_addr[g][7:0]] :
                              (16'hA5B5 ^ {8'h00, mem_addr[g][7:0]});

        mem_port_arbiter #(
            .MEM_LATENCY (g == 0 ? 2 : 1),
            .STARVE_LIMIT(g == 0 ? 4 : 1)
        ) u_dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .i_req        (i_req[g]),
            .i_addr       (i_addr[g]),
            .i_rdata      (i_rdata[g]),
            .i_ack        (i_ack[g]),
            .d_req        (d_req[g]),
            .d_we         (d_we[g]),
            .d_addr       (d_addr[g]),
            .d_wdata      (d_wdata[g]),
            .d_rdata      (d_rdata[g]),
            .d_ack        (d_ack[g]),
            .mem_read     (mem_read[g]),
            .mem_write    (mem_write[g]),
            .mem_addr     (mem_addr[g]),
            .mem_wdata    (mem_wdata[g]),
            .mem_rdata    (mem_rdata[g]),
            .stat_i_wait  (stat_i_wait[g]),
            .stat_d_grants(stat_d_grants[g])
        );
    end

    // Model: m_ph counts cycles since the grant (0 = free, 1..L = access, L+1 = ack).
    int        m_ph[2], m_st[2];
    bit        m_own[2], m_we[2];
    bit [15:0] m_addr[2], m_wd[2], m_ir[2], m_dr[2], m_iw[2], m_dg[2];
    bit        sh_v[2][256];
    bit [15:0] sh_d[2][256];

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int slim_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic bit [15:0] mem_exp(input int k, input bit [15:0] a);
        return sh_v[k][a[7:0]] ? sh_d[k][a[7:0]] : (16'hA5B5 ^ {8'h00, a[7:0]});
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                m_ph[k] <= 0;  m_st[k] <= 0;  m_own[k] <= 1'b0; m_we[k] <= 1'b0;
                m_addr[k] <= '0; m_wd[k] <= '0; m_ir[k] <= '0; m_dr[k] <= '0;
                m_iw[k] <= '0; m_dg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_ph[k] == 0) begin
                    if (d_req[k] && (!i_req[k] || m_st[k] < slim_of(k))) begin
                        m_own[k] <= 1'b1; m_we[k] <= d_we[k];
                        m_addr[k] <= d_addr[k]; m_wd[k] <= d_wdata[k];
                        m_st[k] <= i_req[k] ? m_st[k] + 1 : 0;
                        m_dg[k] <= (m_dg[k] == 16'hFFFF) ? m_dg[k] : m_dg[k] + 16'd1;
                        m_ph[k] <= 1;
                    end else if (i_req[k]) begin
                        m_own[k] <= 1'b0; m_we[k] <= 1'b0;
                        m_addr[k] <= i_addr[k]; m_wd[k] <= '0;
                        m_st[k] <= 0;
                        m_ph[k] <= 1;
                    end
                end else if (m_ph[k] == lat_of(k)) begin
                    if (m_we[k]) begin
                        sh_v[k][m_addr[k][7:0]] <= 1'b1;
                        sh_d[k][m_addr[k][7:0]] <= m_wd[k];
                    end else if (m_own[k]) begin
                        m_dr[k] <= mem_exp(k, m_addr[k]);
                    end else begin
                        m_ir[k] <= mem_exp(k, m_addr[k]);
                    end
                    m_ph[k] <= m_ph[k] + 1;
                end else if (m_ph[k] < lat_of(k)) begin
                    m_ph[k] <= m_ph[k] + 1;
                end else begin
                    m_ph[k] <= 0;
                end
                if (i_req[k] && !(m_ph[k] == lat_of(k) + 1 && !m_own[k]) && m_iw[k] != 16'hFFFF)
                    m_iw[k] <= m_iw[k] + 16'd1;
`ifdef ARB_STATS_EN
                if (poke[k]) m_iw[k] <= 16'hFFFF;
`endif
            end
        end
    end

    task automatic chk(input int k, input string name, input logic [15:0] act, input logic [15:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s[%0d] @%0t: got %h, want %h", name, k, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            bit s, dn;
            s  = (m_ph[k] >= 1) && (m_ph[k] <= lat_of(k));
            dn = (m_ph[k] == lat_of(k) + 1);
            chk(k, "mem_read",  {15'b0, mem_read[k]},  {15'b0, s && !m_we[k]});
            chk(k, "mem_write", {15'b0, mem_write[k]}, {15'b0, s && m_we[k]});
            chk(k, "mem_addr",  mem_addr[k], s ? m_addr[k] : 16'h0000);
            if (!(s && !m_we[k]))
                chk(k, "mem_wdata", mem_wdata[k], s ? m_wd[k] : 16'h0000);
            chk(k, "i_ack",   {15'b0, i_ack[k]}, {15'b0, dn && !m_own[k]});
            chk(k, "d_ack",   {15'b0, d_ack[k]}, {15'b0, dn && m_own[k]});
            chk(k, "i_rdata", i_rdata[k], m_ir[k]);
            chk(k, "d_rdata", d_rdata[k], m_dr[k]);
`ifdef ARB_STATS_EN
            chk(k, "stat_i_wait",   stat_i_wait[k],   m_iw[k]);
            chk(k, "stat_d_grants", stat_d_grants[k], m_dg[k]);
`else
            chk(k, "stat_i_wait",   stat_i_wait[k],   16'h0000);
            chk(k, "stat_d_grants", stat_d_grants[k], 16'h0000);
`endif
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_ack(input int k, input bit is_d, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(is_d ? d_ack[k] : i_ack[k]) && n < budget);
        if (!(is_d ? d_ack[k] : i_ack[k]))
            chk(k, "ack_timeout", 16'h0000, 16'h0001);
    endtask

    initial begin
        int         cyc, nacks, n, cnt;
        logic [9:0] order;

        reset_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            i_req[k] = 1'b0; d_req[k] = 1'b0; d_we[k] = 1'b0; poke[k] = 1'b0;
            i_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
        end
        #1 reset_n = 1'b0;
        tick();
        chk(0, "rst_read", {15'b0, mem_read[0]}, 16'h0000);
        chk(0, "rst_irdata", i_rdata[0], 16'h0000);
        tick();
        reset_n = 1'b1;
        tick();

        // Fetch only.
        i_addr[0] = 16'h0010; i_req[0] = 1'b1;
        tick();
        chk(0, "t1_read_c1", {15'b0, mem_read[0]}, 16'h0001);
        chk(0, "t1_addr_c1", mem_addr[0], 16'h0010);
        tick();
        chk(0, "t1_read_c2", {15'b0, mem_read[0]}, 16'h0001);
        tick();
        chk(0, "t1_ack", {15'b0, i_ack[0]}, 16'h0001);
        chk(0, "t1_rdata", i_rdata[0], 16'hA5A5);
        i_req[0] = 1'b0;
        tick();

        // Load, store, reload of 0x0040.
        d_addr[0] = 16'h0040; d_we[0] = 1'b0; d_req[0] = 1'b1;
        wait_ack(0, 1'b1, 8, cyc);
        chk(0, "t2_load", d_rdata[0], 16'hA5F5);
        d_req[0] = 1'b0;
        tick();
        d_we[0] = 1'b1; d_wdata[0] = 16'h1234; d_req[0] = 1'b1;
        tick();
        chk(0, "t2_write_c1", {15'b0, mem_write[0]}, 16'h0001);
        chk(0, "t2_addr", mem_addr[0], 16'h0040);
        chk(0, "t2_wdata", mem_wdata[0], 16'h1234);
        tick();
        chk(0, "t2_write_c2", {15'b0, mem_write[0]}, 16'h0001);
        tick();
        chk(0, "t2_ack", {15'b0, d_ack[0]}, 16'h0001);
        chk(0, "t2_rdata_kept", d_rdata[0], 16'hA5F5);
        d_req[0] = 1'b0; d_we[0] = 1'b0;
        tick();
        d_req[0] = 1'b1;
        wait_ack(0, 1'b1, 8, cyc);
        chk(0, "t2_reload", d_rdata[0], 16'h1234);
        d_req[0] = 1'b0;
        tick();

        // Top address, no wrap.
        d_addr[0] = 16'hFFFF; d_req[0] = 1'b1;
        tick();
        chk(0, "ffff_addr", mem_addr[0], 16'hFFFF);
        wait_ack(0, 1'b1, 8, cyc);
        chk(0, "ffff_data", d_rdata[0], 16'hA54A);
        d_req[0] = 1'b0;
        tick();

        // Request dropped while busy still completes.
        d_addr[0] = 16'h0020; d_req[0] = 1'b1;
        tick();
        d_req[0] = 1'b0;
        wait_ack(0, 1'b1, 6, cyc);
        chk(0, "drop_busy_lat", 16'(cyc), 16'd2);
        tick();

        // Fetch raised and dropped before the arbiter is free is never granted.
        d_addr[0] = 16'h0030; d_req[0] = 1'b1;
        tick();
        i_addr[0] = 16'h0050; i_req[0] = 1'b1;
        tick();
        tick();
        i_req[0] = 1'b0; d_req[0] = 1'b0;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (i_ack[0]) cnt++;
        end
        chk(0, "drop_idle_acks", 16'(cnt), 16'd0);

        // Contention, STARVE_LIMIT=4.
        i_addr[0] = 16'h0100; d_addr[0] = 16'h0008; d_we[0] = 1'b0;
        i_req[0] = 1'b1; d_req[0] = 1'b1;
        order = '0; nacks = 0; n = 0;
        while (nacks < 10 && n < 80) begin
            tick(); n++;
            if (d_ack[0] || i_ack[0]) begin
                order = {order[8:0], d_ack[0]};
                nacks++;
            end
        end
        i_req[0] = 1'b0; d_req[0] = 1'b0;
        chk(0, "t3_order", {6'b0, order}, 16'h03DE);
        tick();

        // Reset during the first busy cycle of a store.
        d_addr[0] = 16'h0060; d_wdata[0] = 16'hBEEF; d_we[0] = 1'b1; d_req[0] = 1'b1;
        tick();
        chk(0, "t4_write_pre", {15'b0, mem_write[0]}, 16'h0001);
        reset_n = 1'b0; d_req[0] = 1'b0; d_we[0] = 1'b0;
        #1;
        chk(0, "t4_write_drop", {15'b0, mem_write[0]}, 16'h0000);
        chk(0, "t4_no_ack", {15'b0, d_ack[0]}, 16'h0000);
        tick();
        reset_n = 1'b1;
        tick();
        i_addr[0] = 16'h0060; i_req[0] = 1'b1;
        wait_ack(0, 1'b0, 8, cyc);
        chk(0, "t4_idle_lat", 16'(cyc), 16'd3);
        chk(0, "t4_mem_kept", i_rdata[0], 16'hA5D5);
        i_req[0] = 1'b0;
        tick();

`ifdef ARB_STATS_EN
        force g_dut[0].u_dut.i_wait_q = 16'hFFFF;
        poke[0] = 1'b1;
        tick();
        release g_dut[0].u_dut.i_wait_q;
        poke[0] = 1'b0;
        i_addr[0] = 16'h0100; d_addr[0] = 16'h0008; d_we[0] = 1'b0;
        i_req[0] = 1'b1; d_req[0] = 1'b1;
        wait_ack(0, 1'b0, 30, cyc);
        i_req[0] = 1'b0; d_req[0] = 1'b0;
        chk(0, "stat_sat", stat_i_wait[0], 16'hFFFF);
        tick();
`endif

        // MEM_LATENCY=1: alternating single loads.
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) begin
                i_addr[1] = 16'h0080 + 16'(k); i_req[1] = 1'b1;
            end else begin
                d_addr[1] = 16'h0090 + 16'(k); d_we[1] = 1'b0; d_req[1] = 1'b1;
            end
            wait_ack(1, (k % 2) == 1, 10, cyc);
            chk(1, "t5_lat", 16'(cyc), 16'd2);
            if (k == 0) chk(1, "t5_data0", i_rdata[1], 16'hA535);
            i_req[1] = 1'b0; d_req[1] = 1'b0;
            tick();
        end

        // STARVE_LIMIT=1: strict alternation.
        i_addr[1] = 16'h0011; d_addr[1] = 16'h0022;
        i_req[1] = 1'b1; d_req[1] = 1'b1;
        order = '0; nacks = 0; n = 0;
        while (nacks < 6 && n < 40) begin
            tick(); n++;
            if (d_ack[1] || i_ack[1]) begin
                order = {order[8:0], d_ack[1]};
                nacks++;
            end
        end
        i_req[1] = 1'b0; d_req[1] = 1'b0;
        chk(1, "alt_order", {6'b0, order}, 16'h002A);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
